instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter DEPTH, default 4: fetch-buffer entries; legal range 3..8.
REQ-002 Parameter RESET_PC, default 64'h0: PC loaded on reset.
REQ-003 One clock; reset is synchronous and active-low. Clock port is clk; reset port is reset; reset is asserted when 0.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 imem_req  output  1  instruction-memory read strobe.
REQ-007 imem_addr  output  64  byte address of request (PC_Out).
REQ-008 imem_rdata  input  32  instruction word, valid exactly one cycle after imem_req.
REQ-009 redirect  input  1  branch/jump taken; flush and refetch.
REQ-010 redirect_pc  input  64  new fetch address (Adder2Out); bits [1:0] ignored and treated as 0.
REQ-011 id_valid  output  1  head entry presented to decode.
REQ-012 id_ready  input  1  decode accepts head this cycle.
REQ-013 id_instr  output  32  head instruction.
REQ-014 id_pc  output  64  address of head instruction.
REQ-015 buf_count  output  4  occupied buffer entries.

Function
REQ-016 Fetch PC register: pc; imem_addr = pc combinationally.
REQ-017 imem_req = 1 iff reset high, redirect low, and buf_count + inflight < DEPTH (inflight = request issued previous cycle, response not yet written).
REQ-018 On an issuing cycle pc <= pc + 4, modulo 2^64 (all-ones wraps to 0, no flag).
REQ-019 Response in cycle N+1 for request in cycle N is written at buffer tail with its pc at end of N+1; earliest id_valid is cycle N+2.
REQ-020 id_valid = (buf_count != 0); id_instr/id_pc come from the head entry and stay stable while id_valid=1 and id_ready=0.
REQ-021 Pop occurs when id_valid and id_ready; push and pop in the same cycle leave buf_count unchanged.
REQ-022 Head/tail pointers wrap modulo DEPTH; the credit rule in REQ-017 makes overflow impossible, and a push into a full buffer is a design error (assertion).
REQ-023 Sustained throughput is 1 instruction/cycle while id_ready=1 and there is no redirect.
REQ-024 Redirect has priority over issue, push and pop: buffer is emptied, the inflight response is discarded, pc <= {redirect_pc[63:2],2'b00}, imem_req=0 that cycle.
REQ-025 The first request to the new target is issued the cycle after redirect; id_valid=0 from the cycle after redirect until that response lands.
REQ-026 Back-to-back redirects: each one applies REQ-024; the last one wins.
REQ-027 A handshake (pop) in the redirect cycle is honoured by decode but does not change post-flush state.

Reset
REQ-028 While reset=0 at a clock edge: pc <= RESET_PC, buf_count <= 0, pointers <= 0, inflight <= 0.
REQ-029 During reset: imem_req=0, id_valid=0; id_instr=32'h00000013 (NOP), id_pc=RESET_PC.
REQ-030 Reset mid-operation overrides redirect and any in-flight response; the response arriving the cycle after reset release is dropped.

Structure
REQ-031 Shared package rv_pipe_pkg holds XLEN=64, ILEN=32, NOP_INSTR=32'h00000013, and the fetch-entry struct {pc, instr}.
REQ-032 One sub-module, fetch_fifo (DEPTH entries of the fetch-entry struct, push/pop/flush, count); PC/credit logic is in instr_fetch_stage.

Verification
REQ-033 Reset release, id_ready=1, memory returns addr>>2 -> imem_addr 0,4,8,... one per cycle; id_valid first in cycle 2 with id_pc=0; then one instruction/cycle.
REQ-034 id_ready=0 for 10 cycles -> buf_count saturates at 4, imem_req drops, no entry lost; after id_ready=1, id_pc continues 0,4,8,12,16 in order.
REQ-035 redirect with redirect_pc=0x100 while 3 entries buffered and 1 inflight -> next cycle buf_count=0, imem_addr=0x100; first id_pc=0x100, no stale PCs.
REQ-036 redirect_pc=0x203 -> fetch resumes at 0x200.
REQ-037 redirect in two consecutive cycles (0x40 then 0x80) -> only 0x80 stream is observed.
REQ-038 reset=0 asserted mid-stream with buffer full -> after release pc=RESET_PC, buf_count=0, first id_pc=RESET_PC.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants.
// Fetch entries carry the instruction word and its byte address.
package rv_pipe_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer between instruction memory and decode.
// Flush empties it in one cycle; push/pop may coincide.
module fetch_fifo
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [3:0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && !flush && count_q == 4'(DEPTH))
  );

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC and credit-based request issue into fetch_fifo.
// Redirect flushes the buffer and drops the outstanding response.
module instr_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [3:0]      buf_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] infl_pc_q, infl_pc_d;
  logic            infl_q, infl_d;

  logic            push, pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [3:0]      count;

  always_comb begin
    imem_req   = reset && !redirect &&
                 (count + {3'b000, infl_q} < 4'(DEPTH));
    push       = reset && infl_q && !redirect;
    push_entry = '{pc: infl_pc_q, instr: imem_rdata};
    id_valid   = reset && (count != 4'd0);
    pop        = id_valid && id_ready && !redirect;
    id_instr   = reset ? head.instr : NOP_INSTR;
    id_pc      = reset ? head.pc : RESET_PC;
    imem_addr  = pc_q;
    buf_count  = count;
  end

  always_comb begin
    pc_d      = pc_q;
    infl_d    = imem_req;
    infl_pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end else if (imem_req) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage against a queue-based model.
// Memory returns addr>>2 one cycle after each request.
module tb_instr_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [3:0]  buf_count;

  instr_fetch_stage #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .buf_count  (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  bit          m_inf;
  logic [63:0] m_inf_pc;
  bit          e_req;
  bit          e_valid;
  bit          chk_en;
  logic [31:0] rdata_nxt;
  int          errors;
  int          checks;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(
    input bit          rst,
    input bit          rd,
    input logic [63:0] rpc,
    input bit          rdy
  );
    @(negedge clk);
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = rdy;
    imem_rdata  = rdata_nxt;
    #1;
    e_req   = rst && !rd && (q.size() + int'(m_inf) < DEPTH);
    e_valid = rst && (q.size() != 0);
    if (chk_en) begin
      check("req", 64'(imem_req), 64'(e_req));
      check("valid", 64'(id_valid), 64'(e_valid));
      check("count", 64'(buf_count), 64'(q.size()));
      if (e_req) check("addr", imem_addr, m_pc);
      if (!rst) begin
        check("rst_pc", id_pc, RESET_PC);
        check("rst_instr", 64'(id_instr), 64'(NOP));
      end else if (e_valid) begin
        check("id_pc", id_pc, q[0].pc);
        check("id_instr", 64'(id_instr), 64'(q[0].instr));
      end
    end
    rdata_nxt = imem_req ? imem_addr[33:2] : $urandom;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_inf  = 1'b0;
      m_pc   = RESET_PC;
      chk_en = 1'b1;
    end else if (rd) begin
      q.delete();
      m_inf = 1'b0;
      m_pc  = rpc & ~64'h3;
    end else begin
      if (e_valid && rdy) void'(q.pop_front());
      if (m_inf) q.push_back('{m_inf_pc, m_inf_pc[33:2]});
      m_inf    = e_req;
      m_inf_pc = m_pc;
      if (e_req) m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 64'h0, rdy);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    chk_en      = 1'b0;
    m_inf       = 1'b0;
    m_pc        = RESET_PC;
    m_inf_pc    = '0;
    rdata_nxt   = '0;
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    imem_rdata  = '0;

    step(1'b0, 1'b0, 64'h0, 1'b1);
    step(1'b0, 1'b0, 64'h0, 1'b1);
    run(12, 1'b1);
    run(10, 1'b0);
    run(8, 1'b1);
    // three buffered plus one outstanding, then jump
    step(1'b0, 1'b0, 64'h0, 1'b0);
    run(4, 1'b0);
    step(1'b1, 1'b1, 64'h100, 1'b1);
    run(6, 1'b1);
    step(1'b1, 1'b1, 64'h203, 1'b0);
    run(6, 1'b1);
    step(1'b1, 1'b1, 64'h40, 1'b1);
    step(1'b1, 1'b1, 64'h80, 1'b1);
    run(6, 1'b1);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF6, 1'b1);
    run(8, 1'b1);
    run(8, 1'b0);
    step(1'b0, 1'b1, 64'h300, 1'b1);
    run(6, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      bit          rst;
      bit          rd;
      logic [63:0] rpc;
      rst = ($urandom_range(0, 99) != 0);
      rd  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0)
        rpc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      else
        rpc = {$urandom, $urandom};
      step(rst, rd, rpc, ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
